// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control/handshake bundle between the controller (master) and the datapath/memory (slave)
interface multicycle_controller_if;
  logic [6:0] op;
  logic       mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  modport master (
    input  op, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc
  );
  modport slave (
    output op, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle RV32I control FSM; MULTICYCLE_IMM_ALU_EN adds the I-type ALU path (EXECUTEI)
module multicycle_controller #(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus,
  output logic                   illegal,
  output logic [CNT_W-1:0]       retired,
  output logic [STATE_W-1:0]     state_dbg
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB, EXECUTER, ALUWB, BEQ, FAULT
`ifdef MULTICYCLE_IMM_ALU_EN
    , EXECUTEI
`endif
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             req, mw, adr, irw, pcu, br, rw;
  logic [1:0]       rs, sa, sb, aop;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  always_comb begin
    state_d = state_q;
    {req, mw, adr, irw, pcu, br, rw} = '0;
    rs  = 2'b00;
    sa  = 2'b00;
    sb  = 2'b00;
    aop = 2'b00;
    case (state_q)
      FETCH: begin
        req = 1'b1;
        irw = bus.mem_ready;
        pcu = bus.mem_ready;
        rs  = 2'b10;
        sb  = 2'b10;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        sa = 2'b01;
        sb = 2'b01;
        if (bus.op == OP_LW || bus.op == OP_SW) state_d = MEMADR;
        else if (bus.op == OP_R) state_d = EXECUTER;
        else if (bus.op == OP_BEQ) state_d = BEQ;
`ifdef MULTICYCLE_IMM_ALU_EN
        else if (bus.op == OP_I) state_d = EXECUTEI;
`endif
        else state_d = FAULT;
      end
      MEMADR: begin
        sa = 2'b10;
        sb = 2'b01;
        state_d = bus.op == OP_LW ? MEMREAD : bus.op == OP_SW ? MEMWRITE : FAULT;
      end
      MEMREAD: begin
        req = 1'b1;
        adr = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWRITE: begin
        req = 1'b1;
        mw  = 1'b1;
        adr = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      MEMWB: begin
        rs = 2'b01;
        rw = 1'b1;
        state_d = FETCH;
      end
      EXECUTER: begin
        sa  = 2'b10;
        aop = 2'b10;
        state_d = ALUWB;
      end
`ifdef MULTICYCLE_IMM_ALU_EN
      EXECUTEI: begin
        sa  = 2'b10;
        sb  = 2'b01;
        aop = 2'b10;
        state_d = ALUWB;
      end
`endif
      ALUWB: begin
        rw = 1'b1;
        state_d = FETCH;
      end
      BEQ: begin
        sa  = 2'b10;
        aop = 2'b01;
        br  = 1'b1;
        state_d = FETCH;
      end
      FAULT: state_d = FAULT;
      default: state_d = FETCH;
    endcase
    retired_d = (state_d == FETCH && state_q inside {MEMWRITE, MEMWB, ALUWB, BEQ}) ? retired_q + CNT_W'(1) : retired_q;
  end
  // Outputs are gated by rst so they drop the instant reset asserts, not on the next edge.
  assign bus.mem_req   = rst & req;
  assign bus.MemWrite  = rst & mw;
  assign bus.AdrSrc    = rst & adr;
  assign bus.IRWrite   = rst & irw;
  assign bus.PCUpdate  = rst & pcu;
  assign bus.Branch    = rst & br;
  assign bus.RegWrite  = rst & rw;
  assign bus.ResultSrc = rst ? rs : 2'b00;
  assign bus.ALUSrcA   = rst ? sa : 2'b00;
  assign bus.ALUSrcB   = rst ? sb : 2'b00;
  assign bus.ALUOp     = rst ? aop : 2'b00;
  assign bus.ImmSrc    = !rst ? 2'b00 : bus.op == OP_SW ? 2'b01 : bus.op == OP_BEQ ? 2'b10 : 2'b00;
  assign illegal       = rst & (state_q == FAULT);
  assign retired       = retired_q;
  assign state_dbg     = STATE_W'(state_q);
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized scoreboard bench; expected per-cycle outputs come from a phase-list model of each instruction
module tb_multicycle_controller;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] BQ = 7'b1100011, IT = 7'b0010011, BAD = 7'b1111111;
`ifdef MULTICYCLE_IMM_ALU_EN
  localparam int NOPS = 5;
`else
  localparam int NOPS = 4;
`endif
  typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWRITE, P_MEMWB,
                    P_EXR, P_EXI, P_ALUWB, P_BEQ, P_FAULT} ph_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        illegal;
  logic [31:0] retired;
  logic [3:0]  state_dbg;
  multicycle_controller_if bus();
  multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus), .illegal(illegal), .retired(retired), .state_dbg(state_dbg));
  always #5 clk = ~clk;

  logic [49:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] ret_m = 0;
  logic [6:0]  ops [5] = '{LW, SW, RT, BQ, IT};

  function automatic logic [16:0] ctrl(ph_t p, logic mr, logic [6:0] o);
    logic req = 0, mw = 0, adr = 0, irw = 0, pcu = 0, br = 0, rw = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, aop = 0, imm;
    case (p)
      P_FETCH:    begin req = 1; irw = mr; pcu = mr; rs = 2'b10; sb = 2'b10; end
      P_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      P_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      P_MEMREAD:  begin req = 1; adr = 1; end
      P_MEMWRITE: begin req = 1; mw = 1; adr = 1; end
      P_MEMWB:    begin rs = 2'b01; rw = 1; end
      P_EXR:      begin sa = 2'b10; aop = 2'b10; end
      P_EXI:      begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      P_ALUWB:    rw = 1;
      P_BEQ:      begin sa = 2'b10; aop = 2'b01; br = 1; end
      default:    ;
    endcase
    imm = o == SW ? 2'b01 : o == BQ ? 2'b10 : 2'b00;
    return {req, mw, adr, irw, pcu, br, rw, rs, sa, sb, aop, imm};
  endfunction

  function automatic logic [49:0] got_v();
    return {bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCUpdate, bus.Branch, bus.RegWrite,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, illegal, retired};
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom);
  endfunction

  function automatic logic rnd_b();
    return 1'($urandom);
  endfunction

  task automatic chk(string name, logic [49:0] g, logic [49:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, g, e);
    end
  endtask

  // One clock of stimulus: drive inputs just after the edge and queue the outputs that cycle must show.
  task automatic cyc(ph_t p, logic mr, logic [6:0] o);
    bus.op = o;
    bus.mem_ready = mr;
    exp_q.push_back({ctrl(p, mr, o), p == P_FAULT, ret_m});
    @(posedge clk);
    #1;
  endtask

  task automatic mem_phase(ph_t p);
    int s = $urandom_range(0, 3);
    repeat (s) cyc(p, 1'b0, rnd_op());
    cyc(p, 1'b1, rnd_op());
  endtask

  task automatic run_instr(logic [6:0] o, int fault_cycles);
    mem_phase(P_FETCH);
    cyc(P_DECODE, rnd_b(), o);
    if (o == LW || o == SW) begin
      cyc(P_MEMADR, rnd_b(), o);
      if (o == LW) begin
        mem_phase(P_MEMREAD);
        cyc(P_MEMWB, rnd_b(), rnd_op());
      end else mem_phase(P_MEMWRITE);
      ret_m++;
    end else if (o == RT) begin
      cyc(P_EXR, rnd_b(), rnd_op());
      cyc(P_ALUWB, rnd_b(), rnd_op());
      ret_m++;
    end else if (o == BQ) begin
      cyc(P_BEQ, rnd_b(), rnd_op());
      ret_m++;
    end
`ifdef MULTICYCLE_IMM_ALU_EN
    else if (o == IT) begin
      cyc(P_EXI, rnd_b(), rnd_op());
      cyc(P_ALUWB, rnd_b(), rnd_op());
      ret_m++;
    end
`endif
    else repeat (fault_cycles) cyc(P_FAULT, rnd_b(), rnd_op());
  endtask

  task automatic pulse_reset(string name);
    rst = 1'b0;
    #1;
    chk(name, got_v(), '0);
    ret_m = 0;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    rst = 1'b1;
  endtask

  always @(negedge clk)
    if (rst && exp_q.size() > 0) chk("cycle_out", got_v(), exp_q.pop_front());

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.op = 7'd0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", got_v(), '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) run_instr(BQ, 0);
    run_instr(RT, 0);
    run_instr(LW, 0);
    run_instr(SW, 0);
    repeat (40) run_instr(ops[$urandom_range(0, NOPS - 1)], 0);
    run_instr(BAD, 6);
    pulse_reset("fault_reset");
    run_instr(RT, 0);
    run_instr(IT, 5);
    pulse_reset("itype_reset");
    run_instr(RT, 0);
    cyc(P_FETCH, 1'b1, rnd_op());
    cyc(P_DECODE, rnd_b(), SW);
    cyc(P_MEMADR, rnd_b(), SW);
    cyc(P_MEMWRITE, 1'b0, rnd_op());
    bus.mem_ready = 1'b0;
    chk("memwrite_stall", 50'({bus.mem_req, bus.MemWrite, retired}), 50'({2'b11, ret_m}));
    #1;
    rst = 1'b0;
    #1;
    chk("async_abort", 50'({bus.mem_req, bus.MemWrite, retired}), '0);
    ret_m = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_instr(LW, 0);
    run_instr(RT, 0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) chk("queue_drain", 50'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences a shared-memory, multi-cycle RV32I datapath (one ALU, one unified instruction/data memory).
- Runs one instruction per multi-cycle pass: fetch, decode, execute, memory, writeback.
- Drives every datapath mux select and write strobe, handshakes with memory, retires instructions into a counter and traps illegal opcodes.
- Sits beside the datapath; takes op from the instruction register.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- STATE_W, 4, width of the state-register debug output.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- op  in  7  opcode field of the instruction register.
- mem_ready  in  1  memory completed the current access this cycle.
- mem_req  out  1  memory access request.
- MemWrite  out  1  write qualifier for mem_req.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- IRWrite  out  1  load instruction register and OldPC.
- PCUpdate  out  1  load PC with Result.
- Branch  out  1  PC load if ALU Zero.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 RegA.
- ALUSrcB  out  2  ALU B select: 00 RegB, 01 ImmExt, 10 constant 4.
- ALUOp  out  2  to alu_decoder: 00 add, 01 sub, 10 funct-decoded.
- ImmSrc  out  2  immediate format.
- illegal  out  1  sticky illegal-opcode flag.
- retired  out  CNT_W  count of completed instructions.
- state_dbg  out  STATE_W  current state encoding.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = FETCH, retired = 0, illegal = 0.
  - While rst = 0, all outputs are forced to 0, including mem_req.
- Opcodes: LW 0000011, SW 0100011, R 0110011, BEQ 1100011.
- ImmSrc is combinational from op: SW 01, BEQ 10, otherwise 00.
- All other outputs are Moore outputs of the state, except the mem_ready-qualified strobes noted below. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_req = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10.
  - IRWrite = PCUpdate = mem_ready.
  - Holds until mem_ready = 1, then goes to DECODE.
- DECODE:
  - Outputs: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (branch target into ALUOut).
  - Next state: LW/SW -> MEMADR, R -> EXECUTER, BEQ -> BEQ, any other op -> FAULT.
- MEMADR:
  - Outputs: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00.
  - Next state: LW -> MEMREAD, SW -> MEMWRITE.
- MEMREAD:
  - Outputs: mem_req = 1, AdrSrc = 1, ResultSrc = 00.
  - Holds until mem_ready, then goes to MEMWB.
- MEMWRITE:
  - Outputs: mem_req = 1, MemWrite = 1, AdrSrc = 1, ResultSrc = 00.
  - Holds until mem_ready; the write commits on the mem_ready cycle. Then goes to FETCH and retires.
- MEMWB: ResultSrc = 01, RegWrite = 1; goes to FETCH and retires.
- EXECUTER: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10; goes to ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1; goes to FETCH and retires.
- BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, Branch = 1; goes to FETCH and retires.
- FAULT:
  - illegal = 1; all strobes are 0.
  - Absorbing; only reset exits.
- Latency with mem_ready held at 1: LW 5, SW 4, R 4, BEQ 3 cycles.
- Each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle; all outputs stay stable while stalled.
- retired:
  - Increments by 1 on each transition into FETCH from MEMWRITE, MEMWB, ALUWB or BEQ.
  - Wraps modulo 2^CNT_W.
  - Holds in FAULT.
- op is sampled only in DECODE and MEMADR; op changes in other states have no effect.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.
- Reset asserted mid-instruction: aborts immediately, with no partial strobe on the following edge.
- Unused state encodings go to FETCH on the next clock.

Optional Feature:
- Macro: MULTICYCLE_IMM_ALU_EN.
- Defined:
  - op 0010011 (I-type ALU) decodes DECODE -> EXECUTEI -> ALUWB, then retires.
  - EXECUTEI outputs: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10.
  - Latency is 4 cycles; ImmSrc = 00.
- Not defined: 0010011 is illegal and goes to FAULT. The EXECUTEI state and its encoding do not exist.

Test Plan:
- Reset release, op = 0110011, mem_ready = 1 -> states FETCH, DECODE, EXECUTER, ALUWB; RegWrite = 1 only in ALUWB; retired = 1 after 4 cycles.
- LW with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD -> IRWrite/PCUpdate pulse once; MEMWB reached after 10 cycles; retired += 1.
- SW, mem_ready = 1 -> MemWrite = 1 and AdrSrc = 1 only in MEMWRITE; ImmSrc = 01; RegWrite is never 1; 4 cycles.
- BEQ -> Branch = 1 and ALUOp = 01 for exactly one cycle; 3 cycles per instruction; 4 back-to-back BEQs give retired = 4.
- op = 1111111 in DECODE -> FAULT; illegal = 1 and held; retired frozen; rst low then high clears illegal and restarts in FETCH.
- rst asserted during MEMWRITE stall -> mem_req and MemWrite drop to 0 asynchronously; retired = 0.
- With MULTICYCLE_IMM_ALU_EN, op 0010011 -> EXECUTEI with ALUSrcB = 01, then ALUWB. Without the macro -> FAULT.
